// File: rtl/nibble_pc_sequencer.sv
// Program counter and fetch/execute sequencer for the Nibble CPU fetch path.
// Also keeps a saturating count of executed instructions for debug.
module nibble_pc_sequencer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   jump,
  input  logic [ADDR_WIDTH-1:0]  jump_addr,
  input  logic                   halt,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   phase,
  output logic                   fetch_strobe,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  // state     | meaning
  // S_FETCH   | byte at pc is on the ROM bus; Fetch latches it when run=1
  // S_EXECUTE | decode's halt/jump decision is applied and pc advances
  // S_HALTED  | absorbing; only reset leaves
  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_EXECUTE = 2'b01,
    S_HALTED  = 2'b10
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  w_pc_nxt;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_count_nxt;
  logic                   w_count_sat;

  assign w_count_sat = &r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_count_nxt = r_count;
    case (r_state)
      S_FETCH: begin
        if (run) w_state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (run) begin
          if (!w_count_sat) w_count_nxt = r_count + COUNT_WIDTH'(1);
          if (halt) begin
            w_state_nxt = S_HALTED;
          end else begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = jump ? jump_addr : r_pc + ADDR_WIDTH'(1);
          end
        end
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // Encoding chosen so phase and halted come straight off state flops.
  assign phase        = r_state[0];
  assign halted       = r_state[1];
  assign pc           = r_pc;
  assign instr_count  = r_count;
  assign fetch_strobe = (r_state == S_FETCH) && run;

endmodule

// File: doc/nibble_pc_sequencer.md
Name: nibble_pc_sequencer

Overview:
- Upstream stage of the Fetch block in the Nibble CPU.
- Holds the program counter that addresses program ROM and sequences the two-phase fetch/execute cycle.
- In FETCH it tells Fetch to latch the ROM byte into instruction/operand. In EXECUTE it takes the branch/halt decision from decode and advances the PC.
- It also keeps a saturating count of executed instructions for debug.

Parameters:
- ADDR_WIDTH, 12, program ROM address width; PC wraps modulo 2^ADDR_WIDTH.
- COUNT_WIDTH, 16, width of the executed-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  advance enable. When low, all state holds.
- jump  in  1  taken-branch request from decode. Sampled only in EXECUTE.
- jump_addr  in  ADDR_WIDTH  branch target. Sampled with jump.
- halt  in  1  halt request from decode. Sampled only in EXECUTE.
- pc  out  ADDR_WIDTH  registered ROM address, which drives programByte lookup.
- phase  out  1  0 = FETCH, 1 = EXECUTE. Registered; 0 in HALTED.
- fetch_strobe  out  1  load enable to Fetch: (state==FETCH) && run. Combinational.
- halted  out  1  registered; 1 while in HALTED.
- instr_count  out  COUNT_WIDTH  executed-instruction count, saturating.

Behaviour:
- Reset (synchronous, highest priority, any state including mid-EXECUTE):
  - next edge gives pc=0, state=FETCH, phase=0, halted=0, instr_count=0.
  - fetch_strobe = run in the first cycle after reset.
- States: FETCH, EXECUTE, HALTED. Two bits are enough; the encoding is free.
- FETCH:
  - run=1: fetch_strobe=1. Fetch latches the byte at the current pc on this edge. Next state is EXECUTE. pc is unchanged.
  - run=0: hold everything; fetch_strobe=0.
- EXECUTE, with run=1. Priority is halt > jump > increment:
  - halt=1: next state HALTED; pc unchanged; instr_count += 1 (the halt instruction counts).
  - else jump=1: pc <= jump_addr; next state FETCH; instr_count += 1.
  - else: pc <= pc + 1, truncated to ADDR_WIDTH (2^ADDR_WIDTH-1 wraps to 0); next state FETCH; instr_count += 1.
- EXECUTE, with run=0: hold; jump, halt and jump_addr are ignored.
- HALTED:
  - absorbing; only reset exits.
  - pc and instr_count are frozen; fetch_strobe=0; phase=0; halted=1.
  - run, jump and halt are ignored.
- instr_count saturates at 2^COUNT_WIDTH-1 and never wraps.
- jump or halt asserted during FETCH has no effect.
- Latency:
  - one instruction takes 2 enabled cycles.
  - the new pc is visible the cycle after the EXECUTE edge.
  - fetch_strobe for the new pc appears in that same cycle.
- pc, phase, halted and instr_count change only on clock edges. fetch_strobe is the only combinational output.
- No X on any output after the first reset edge.

Test Plan:
1. Sequential run: reset, then run=1 for 8 cycles with jump=halt=0.
   - pc goes 0,0,1,1,2,2,3,3.
   - phase alternates 0/1; fetch_strobe is high in phase 0 cycles.
   - instr_count=4 after cycle 8.
2. Jump taken: at pc=3 in EXECUTE, drive jump=1 and jump_addr=0x2A5.
   - next cycle: pc=0x2A5, phase=0, fetch_strobe=1.
   - jump=1 held during FETCH has no effect (pc remains 0x2A5).
3. Wrap and saturation: with ADDR_WIDTH=4 and COUNT_WIDTH=3, run 40 cycles.
   - pc steps 0xF -> 0x0.
   - instr_count stops at 7.
4. Halt priority: in EXECUTE at pc=5, drive halt=1 and jump=1 with jump_addr=0x100.
   - halted=1, pc stays 5, instr_count +1.
   - then run=1, jump=1 for 10 cycles: pc, halted and instr_count are unchanged; fetch_strobe=0.
5. Stall: run=0 for 5 cycles in EXECUTE at pc=7 with jump=1 and jump_addr=0x0FF.
   - pc=7, phase=1 and fetch_strobe=0 throughout.
   - run=1 with jump=0: pc=8.
6. Reset mid-operation: assert reset in EXECUTE at pc=0x123 with jump=1 (and separately while HALTED).
   - next edge: pc=0, phase=0, halted=0, instr_count=0.
   - fetch_strobe follows run.
